// File: rtl/weightmem_port_arbiter_pkg.sv
// Shared types and geometry for the weight-memory bank and its port arbiter.
// Both the bank and the arbiter take their word width from here, so the two always agree.
package weightmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } wm_gnt_e;

    localparam int WEIGHTBANKDEPTH = 512;
    localparam int N_I             = 50;
    localparam int WEIGHT_STAGGER  = 2;
    localparam int TRITS_PER_BYTE  = 5;

    // Ternary weights are packed five trits per byte; partial groups still use a whole byte.
    function automatic int packed_trit_width(input int n_trits);
        return ((n_trits + TRITS_PER_BYTE - 1) / TRITS_PER_BYTE) * 8;
    endfunction

    localparam int WM_DATA_WIDTH = packed_trit_width(N_I / WEIGHT_STAGGER);

    function automatic int addr_width(input int num_words);
        return (num_words <= 1) ? 1 : $clog2(num_words);
    endfunction

    // A limit of zero still needs a one-bit counter to keep the compare well formed.
    function automatic int stall_cnt_width(input int max_stall);
        return (max_stall < 1) ? 1 : $clog2(max_stall + 1);
    endfunction

endpackage

// File: rtl/weightmem_port_arbiter_if.sv
// Requester-side bundle of the weight-memory arbiter: one read port and one write port.
// master = the requesters (weight fetch and weight loader), slave = the arbiter.
interface weightmem_port_arbiter_if
    import weightmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = addr_width(WEIGHTBANKDEPTH),
    parameter int DATA_W = WM_DATA_WIDTH
);

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );

endinterface

// File: rtl/weightmem_port_arbiter.sv
// Shares one single-port weight SRAM bank between the weight fetch (read) and the loader (write).
// Reads win by default; a bounded stall counter forces a write through so loading cannot starve.
module weightmem_port_arbiter
    import weightmem_port_arbiter_pkg::*;
#(
    parameter  int NUM_WORDS       = WEIGHTBANKDEPTH,
    parameter  int DATA_WIDTH      = WM_DATA_WIDTH,
    parameter  int MAX_WRITE_STALL = 8,
    localparam int ADDR_W          = addr_width(NUM_WORDS),
    localparam int CNT_W           = stall_cnt_width(MAX_WRITE_STALL)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    weightmem_port_arbiter_if.slave port_if,

    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [DATA_WIDTH-1:0] sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_WRITE_STALL);

    wm_gnt_e               w_gnt;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;
    logic                  w_stall_max;

    logic [CNT_W-1:0]      r_stall_cnt;
    logic                  r_rd_valid_p1;
    logic [DATA_WIDTH-1:0] r_hold_p1;

    assign w_stall_max = (r_stall_cnt == STALL_LIMIT);

    // Grant decision: purely combinational so a request can be served in the cycle it appears.
    always_comb begin
        w_gnt = GNT_NONE;
        if (port_if.wr_req && (w_stall_max || !port_if.rd_req)) begin
            w_gnt = GNT_WR;
        end else if (port_if.rd_req) begin
            w_gnt = GNT_RD;
        end
    end

    assign w_rd_gnt = (w_gnt == GNT_RD);
    assign w_wr_gnt = (w_gnt == GNT_WR);

    assign port_if.rd_gnt = w_rd_gnt;
    assign port_if.wr_gnt = w_wr_gnt;

    // Bank drive: address and write data come from the winner; an idle bank sees all zeros.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        unique case (w_gnt)
            GNT_RD: begin
                sram_req_o  = 1'b1;
                sram_addr_o = port_if.rd_addr;
            end
            GNT_WR: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = port_if.wr_addr;
                sram_wdata_o = port_if.wr_data;
            end
            default: ;
        endcase
    end

    assign sram_be_o = '1;

    // Counts consecutive cycles a pending write lost; saturates so the force stays asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (!port_if.wr_req || w_wr_gnt) begin
            r_stall_cnt <= '0;
        end else if (!w_stall_max) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // ---- stage p1: bank output arrives one cycle after the read grant ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_valid_p1 <= 1'b0;
            r_hold_p1     <= '0;
        end else begin
            r_rd_valid_p1 <= w_rd_gnt;
            if (r_rd_valid_p1) begin
                r_hold_p1 <= sram_rdata_i;
            end
        end
    end

    // The bank output is only trusted on the valid cycle; otherwise the last word is replayed.
    assign port_if.rd_valid = r_rd_valid_p1;
    assign port_if.rd_data  = r_rd_valid_p1 ? sram_rdata_i : r_hold_p1;

endmodule
